byte_permutation_stream: RTL and testbench
==========================================

# byte_permutation_stream

Byte-serial, parametrised ShiftRows / InvShiftRows permutation unit for the narrow-datapath Rijndael core. It accepts one state lane per cycle in column-major order and emits the same block permuted, in either direction. Data width and column count are parameters, and valid/ready handshakes on both sides allow back-pressure. It sits between the S-box stage and MixColumns, and replaces the fixed 128-bit, forward-only, externally sequenced permutation shift chain.

## Interface
- `W`, default 8: lane width in bits.
- `NB`, default 4: state columns. Legal values are 4, 6 and 8. Any other value is an elaboration error.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the unit can accept a lane.
- `in_data` in W: input lane. Lane index i = r + 4c.
- `in_inv` in 1: selects InvShiftRows when 1. Sampled only on the first lane of a block (write count 0).
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: the downstream stage accepts the lane.
- `out_data` out W: permuted lane, in column-major output order.
- `out_last` out 1: marks the final lane (index 4·NB−1) of the output block.

## Operation
- Block size N = 4·NB lanes.
- Storage is two banks of N×W registers, used ping-pong. Per bank: `full` flag and a latched `inv` bit.
- Write side state: `wbank`, `wcnt` (0..N−1).
  - `in_ready` = !full[wbank].
  - On accept: mem[wbank][wcnt] ← `in_data`.
  - If wcnt==0, latch inv[wbank] ← `in_inv`.
  - If wcnt==N−1: set full[wbank], toggle wbank, wcnt←0. Otherwise wcnt+1.
- Read side state: `rbank`, `rcnt` (0..N−1).
  - `out_valid` = full[rbank].
  - `out_data` = mem[rbank][src(rcnt)].
  - `out_last` = `out_valid` && rcnt==N−1.
  - On accept at rcnt==N−1: clear full[rbank], toggle rbank, rcnt←0. Otherwise rcnt+1.
- Source index for output k, with r = k mod 4 and c = k div 4:
  - Forward: src = r + 4·((c + s_r) mod NB).
  - Inverse: src = r + 4·((c − s_r + NB) mod NB).
  - Offsets s = {0,1,2,3} for NB=4 and NB=6; s = {0,1,3,4} for NB=8.
- Mode is fixed per block. Toggling `in_inv` mid-block has no effect.
- Simultaneous events:
  - A read may clear full[b] in the same cycle a write sets full[!b]. Both take effect.
  - A single bank can never be set and cleared in the same cycle, because a write requires !full.
- Both banks full: `in_ready`=0 until the read side drains the last lane of rbank. `in_ready` rises in the cycle after that accept.
- Reset (asynchronous, any time, including mid-block):
  - wcnt, rcnt, wbank, rbank, full and inv all clear to 0.
  - All mem registers clear to 0.
  - Partial blocks are discarded.
  - Outputs: `out_valid`=0, `out_last`=0, `out_data`=0, `in_ready`=1.

## Timing
- `out_data`, `out_valid` and `out_last` are combinational from registered state only. There is no path from `in_*` to `out_*`.
- `in_ready` depends only on registered state. There is no path from `out_ready`.
- Latency: first output lane is valid in the cycle after the last input lane of the block is accepted. That is N cycles from the first input accept, with no stalls.
- Throughput: 1 lane/cycle sustained with both sides always ready. There are no bubbles between blocks.
- `out_data` and `out_last` are held stable while `out_valid`=1 and `out_ready`=0.

## Structure
- Shared package `rijndael_pkg`:
  - Legal-NB check.
  - Function `shift_offset(NB, r)` returning s_r.
  - Constant block size `N(NB)`.
- Sub-module `byte_perm_addr_gen`: combinational, maps (k, inv) to src. Parametrised by NB.
- Top level holds the banks, counters, flags and handshake logic.

## Test plan
- NB=4, W=8, forward, lanes 00..0f streamed → out 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b. `out_last` asserts on 0b. First `out_valid` is 16 cycles after the first accept.
- NB=4, inverse, lanes 00..0f → 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03.
- Back-to-back blocks alternating fwd/inv, `out_ready` held at 1 → no idle cycles, and each block uses its own latched mode. Forward then inverse on the same data round-trips to the identity.
- `out_ready`=0 for 40 cycles while three blocks are offered → `in_ready` drops after 32 accepts. Once drained, the data arrives intact and in order, with `out_data` stable during the stall.
- NB=8, forward, lanes 00..1f → lane k=1 (r1,c0) = 05, k=2 (r2,c0) = 0e, k=3 (r3,c0) = 13. Round-trip with inverse gives the identity. Repeat round-trip for NB=6.
- `rst_n` pulsed low mid-block (after 7 lanes) → outputs go to reset values immediately. The next full block is permuted correctly, with no leftover lanes.

Source files
------------

// File: rtl/rijndael_pkg.sv
// Shared Rijndael helpers for the narrow-datapath core.
// Covers legal column counts, ShiftRows offsets and block size.
package rijndael_pkg;

    function automatic bit nb_is_legal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    // Rows 2 and 3 shift one extra column for 256-bit blocks.
    function automatic int shift_offset(input int nb, input int r);
        return (nb == 8 && r >= 2) ? r + 1 : r;
    endfunction

    function automatic int block_size(input int nb);
        return 4 * nb;
    endfunction

endpackage

// File: rtl/byte_perm_addr_gen.sv
// Combinational source-lane lookup for ShiftRows / InvShiftRows.
// Maps output lane k to the stored lane index that feeds it.
module byte_perm_addr_gen
    import rijndael_pkg::*;
#(
    parameter int NB = 4,
    parameter int AW = $clog2(4 * NB)
) (
    input  logic [AW-1:0] k,
    input  logic          inv,
    output logic [AW-1:0] src
);

    int row;
    int col;
    int shift;
    int src_col;

    always_comb begin
        row   = int'(k) % 4;
        col   = int'(k) / 4;
        shift = shift_offset(NB, row);
        if (inv) begin
            src_col = (col - shift + NB) % NB;
        end else begin
            src_col = (col + shift) % NB;
        end
        src = AW'(row + 4 * src_col);
    end

endmodule

// File: rtl/byte_permutation_stream.sv
// Ping-pong buffered ShiftRows / InvShiftRows unit, one lane per cycle in and out.
// One bank fills while the other drains in permuted order.
module byte_permutation_stream
    import rijndael_pkg::*;
#(
    parameter int W  = 8,
    parameter int NB = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last
);

    localparam int N  = block_size(NB);
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    if (!nb_is_legal(NB)) begin : g_bad_nb
        $error("byte_permutation_stream: NB must be 4, 6 or 8");
    end

    logic [W-1:0]  mem_q [2][N];
    logic [W-1:0]  mem_d [2][N];
    logic [1:0]    full_q, full_d;
    logic [1:0]    inv_q, inv_d;
    logic          wbank_q, wbank_d;
    logic          rbank_q, rbank_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic [AW-1:0] rcnt_q, rcnt_d;
    logic [AW-1:0] src;
    logic          wr_fire;
    logic          rd_fire;

    byte_perm_addr_gen #(
        .NB(NB),
        .AW(AW)
    ) u_addr_gen (
        .k  (rcnt_q),
        .inv(inv_q[rbank_q]),
        .src(src)
    );

    assign in_ready  = !full_q[wbank_q];
    assign out_valid = full_q[rbank_q];
    assign out_data  = mem_q[rbank_q][src];
    assign out_last  = out_valid && (rcnt_q == LAST);
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;

    // Write and read sides touch different banks, so both updates can apply together.
    always_comb begin
        mem_d   = mem_q;
        full_d  = full_q;
        inv_d   = inv_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;

        if (wr_fire) begin
            mem_d[wbank_q][wcnt_q] = in_data;
            if (wcnt_q == '0) begin
                inv_d[wbank_q] = in_inv;
            end
            if (wcnt_q == LAST) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
                wcnt_d          = '0;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end

        if (rd_fire) begin
            if (rcnt_q == LAST) begin
                full_d[rbank_q] = 1'b0;
                rbank_d         = ~rbank_q;
                rcnt_d          = '0;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
            full_q  <= '0;
            inv_q   <= '0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
        end else begin
            mem_q   <= mem_d;
            full_q  <= full_d;
            inv_q   <= inv_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

endmodule

// File: tb/tb_byte_permutation_stream.sv
// Randomised scoreboard bench for byte_permutation_stream at NB = 4, 6 and 8.
// Expected lanes come from a row-rotation model of the state grid.
module tb_byte_permutation_stream;

    logic clk = 1'b0;
    logic rst_n;
    logic [2:0]      in_valid;
    logic [2:0]      in_inv;
    logic [2:0]      out_ready;
    logic [2:0][7:0] in_data;
    wire  [2:0]      in_ready;
    wire  [2:0]      out_valid;
    wire  [2:0]      out_last;
    wire  [2:0][7:0] out_data;

    always #5 clk = ~clk;

    byte_permutation_stream #(.W(8), .NB(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_inv(in_inv[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_last(out_last[0])
    );

    byte_permutation_stream #(.W(8), .NB(6)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_inv(in_inv[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_last(out_last[1])
    );

    byte_permutation_stream #(.W(8), .NB(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]), .in_inv(in_inv[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]), .out_last(out_last[2])
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] txLanes[$];
    bit         txInv[$];
    logic [7:0] expLanes[$];
    logic [7:0] rxLanes[$];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Model the state as a 4 x nb grid and rotate each row one column at a time.
    function automatic void permuteBlock(input int nb, input bit inv, input logic [7:0] blk[$],
                                         output logic [7:0] res[$]);
        logic [7:0] grid[4][8];
        logic [7:0] first;
        int steps;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                grid[r][c] = blk[r + 4 * c];
        for (int r = 0; r < 4; r++) begin
            steps = (nb == 8 && r >= 2) ? r + 1 : r;
            if (inv) steps = nb - steps;
            for (int s = 0; s < steps; s++) begin
                first = grid[r][0];
                for (int c = 0; c < nb - 1; c++) grid[r][c] = grid[r][c + 1];
                grid[r][nb - 1] = first;
            end
        end
        res = {};
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                res.push_back(grid[r][c]);
    endfunction

    // Mid-block in_inv values are randomised; only lane 0 carries the block's mode.
    task automatic queueBlock(input int nb, input logic [7:0] blk[$], input bit inv);
        logic [7:0] res[$];
        permuteBlock(nb, inv, blk, res);
        foreach (blk[i]) begin
            txLanes.push_back(blk[i]);
            txInv.push_back((i == 0) ? inv : 1'($urandom_range(0, 1)));
        end
        foreach (res[i]) expLanes.push_back(res[i]);
    endtask

    task automatic applyStimulus(input int d, input int nb, input bit inGaps, input bit randReady,
                                 input int stallCycles, output int latency, output int bubbles,
                                 output int stallAccepts, output bit readyAtStallEnd);
        int cyc = 0;
        int firstAcc = -1;
        int firstOut = -1;
        int outCount = 0;
        int n = 4 * nb;
        logic [7:0] exp;
        bubbles = 0;
        stallAccepts = 0;
        readyAtStallEnd = 1'b1;
        rxLanes = {};
        while ((txLanes.size() > 0 || expLanes.size() > 0) && cyc < 4000) begin
            @(negedge clk);
            if (txLanes.size() > 0 && (!inGaps || $urandom_range(0, 3) != 0)) begin
                in_valid[d] = 1'b1;
                in_data[d]  = txLanes[0];
                in_inv[d]   = txInv[0];
            end else begin
                in_valid[d] = 1'b0;
                in_data[d]  = 8'($urandom);
                in_inv[d]   = 1'($urandom_range(0, 1));
            end
            if (cyc < stallCycles) out_ready[d] = 1'b0;
            else out_ready[d] = randReady ? 1'($urandom_range(0, 1)) : 1'b1;

            if (out_valid[d] && firstOut < 0) firstOut = cyc;
            if (firstOut >= 0 && !out_valid[d] && expLanes.size() > 0) bubbles++;
            if (cyc < stallCycles && out_valid[d] && expLanes.size() > 0) begin
                checkOutput("stall out_data", 32'(out_data[d]), 32'(expLanes[0]));
                checkOutput("stall out_last", 32'(out_last[d]), 32'(0));
            end
            if (cyc == stallCycles - 1) readyAtStallEnd = in_ready[d];

            if (out_valid[d] && out_ready[d]) begin
                if (expLanes.size() == 0) begin
                    checkOutput("spurious out_valid", 32'(out_valid[d]), 32'(0));
                end else begin
                    exp = expLanes.pop_front();
                    checkOutput("out_data", 32'(out_data[d]), 32'(exp));
                    checkOutput("out_last", 32'(out_last[d]), 32'((outCount % n) == n - 1));
                    rxLanes.push_back(out_data[d]);
                    outCount++;
                end
            end
            if (in_valid[d] && in_ready[d]) begin
                if (firstAcc < 0) firstAcc = cyc;
                if (cyc < stallCycles) stallAccepts++;
                void'(txLanes.pop_front());
                void'(txInv.pop_front());
            end
            cyc++;
        end
        @(negedge clk);
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b0;
        if (txLanes.size() != 0 || expLanes.size() != 0) begin
            checkOutput("drain timeout lanes left", 32'(expLanes.size()), 32'(0));
            txLanes = {};
            txInv = {};
            expLanes = {};
        end
        checkOutput("idle after drain", 32'(out_valid[d]), 32'(0));
        latency = firstOut - firstAcc;
    endtask

    task automatic roundTrip(input int d, input int nb);
        logic [7:0] blk[$];
        logic [7:0] mid[$];
        int lat, bub, sa;
        bit rse;
        for (int i = 0; i < 4 * nb; i++) blk.push_back(8'($urandom));
        queueBlock(nb, blk, 1'b0);
        applyStimulus(d, nb, 1'b1, 1'b1, 0, lat, bub, sa, rse);
        mid = rxLanes;
        queueBlock(nb, mid, 1'b1);
        applyStimulus(d, nb, 1'b1, 1'b1, 0, lat, bub, sa, rse);
        checkOutput("roundtrip size", 32'(rxLanes.size()), 32'(blk.size()));
        for (int i = 0; i < blk.size() && i < rxLanes.size(); i++)
            checkOutput("roundtrip lane", 32'(rxLanes[i]), 32'(blk[i]));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] fwd4[16] = '{8'h00, 8'h05, 8'h0a, 8'h0f, 8'h04, 8'h09, 8'h0e, 8'h03,
                                 8'h08, 8'h0d, 8'h02, 8'h07, 8'h0c, 8'h01, 8'h06, 8'h0b};
        logic [7:0] inv4[16] = '{8'h00, 8'h0d, 8'h0a, 8'h07, 8'h04, 8'h01, 8'h0e, 8'h0b,
                                 8'h08, 8'h05, 8'h02, 8'h0f, 8'h0c, 8'h09, 8'h06, 8'h03};
        logic [7:0] blk[$];
        int lat, bub, sa;
        bit rse;

        rst_n = 1'b0;
        in_valid = '0;
        in_inv = '0;
        out_ready = '0;
        in_data = '0;
        #12;
        $display("[TB] checking reset state");
        for (int d = 0; d < 3; d++) begin
            checkOutput("reset in_ready", 32'(in_ready[d]), 32'(1));
            checkOutput("reset out_valid", 32'(out_valid[d]), 32'(0));
            checkOutput("reset out_data", 32'(out_data[d]), 32'(0));
            checkOutput("reset out_last", 32'(out_last[d]), 32'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] NB=4 forward, sequential lanes");
        blk = {};
        for (int i = 0; i < 16; i++) blk.push_back(8'(i));
        queueBlock(4, blk, 1'b0);
        applyStimulus(0, 4, 1'b0, 1'b0, 0, lat, bub, sa, rse);
        checkOutput("fwd4 latency", 32'(lat), 32'(16));
        checkOutput("fwd4 rx count", 32'(rxLanes.size()), 32'(16));
        for (int i = 0; i < 16 && i < rxLanes.size(); i++)
            checkOutput("fwd4 lane", 32'(rxLanes[i]), 32'(fwd4[i]));

        $display("[TB] NB=4 inverse, sequential lanes");
        queueBlock(4, blk, 1'b1);
        applyStimulus(0, 4, 1'b0, 1'b0, 0, lat, bub, sa, rse);
        checkOutput("inv4 rx count", 32'(rxLanes.size()), 32'(16));
        for (int i = 0; i < 16 && i < rxLanes.size(); i++)
            checkOutput("inv4 lane", 32'(rxLanes[i]), 32'(inv4[i]));

        $display("[TB] NB=4 back-to-back alternating modes");
        for (int b = 0; b < 4; b++) begin
            blk = {};
            for (int i = 0; i < 16; i++) blk.push_back(8'($urandom));
            queueBlock(4, blk, 1'(b % 2));
        end
        applyStimulus(0, 4, 1'b0, 1'b0, 0, lat, bub, sa, rse);
        checkOutput("b2b bubbles", 32'(bub), 32'(0));
        checkOutput("b2b latency", 32'(lat), 32'(16));
        roundTrip(0, 4);

        $display("[TB] NB=4 output stall with three blocks offered");
        for (int b = 0; b < 3; b++) begin
            blk = {};
            for (int i = 0; i < 16; i++) blk.push_back(8'($urandom));
            queueBlock(4, blk, 1'($urandom_range(0, 1)));
        end
        applyStimulus(0, 4, 1'b0, 1'b0, 40, lat, bub, sa, rse);
        checkOutput("stall accepts", 32'(sa), 32'(32));
        checkOutput("stall in_ready", 32'(rse), 32'(0));

        $display("[TB] NB=4 random traffic");
        for (int b = 0; b < 6; b++) begin
            blk = {};
            for (int i = 0; i < 16; i++) blk.push_back(8'($urandom));
            queueBlock(4, blk, 1'($urandom_range(0, 1)));
        end
        applyStimulus(0, 4, 1'b1, 1'b1, 0, lat, bub, sa, rse);

        $display("[TB] NB=8 forward, sequential lanes");
        blk = {};
        for (int i = 0; i < 32; i++) blk.push_back(8'(i));
        queueBlock(8, blk, 1'b0);
        applyStimulus(2, 8, 1'b0, 1'b0, 0, lat, bub, sa, rse);
        checkOutput("fwd8 latency", 32'(lat), 32'(32));
        checkOutput("fwd8 rx count", 32'(rxLanes.size()), 32'(32));
        if (rxLanes.size() >= 4) begin
            checkOutput("fwd8 k1", 32'(rxLanes[1]), 32'(8'h05));
            checkOutput("fwd8 k2", 32'(rxLanes[2]), 32'(8'h0e));
            checkOutput("fwd8 k3", 32'(rxLanes[3]), 32'(8'h13));
        end
        roundTrip(2, 8);

        $display("[TB] NB=6 round trip and random traffic");
        roundTrip(1, 6);
        for (int b = 0; b < 3; b++) begin
            blk = {};
            for (int i = 0; i < 24; i++) blk.push_back(8'($urandom));
            queueBlock(6, blk, 1'($urandom_range(0, 1)));
        end
        applyStimulus(1, 6, 1'b1, 1'b1, 0, lat, bub, sa, rse);

        $display("[TB] NB=4 reset mid-block");
        @(negedge clk);
        in_valid[0] = 1'b1;
        out_ready[0] = 1'b0;
        for (int i = 0; i < 23; i++) begin
            in_data[0] = 8'(8'h40 + i);
            in_inv[0] = 1'b0;
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        checkOutput("pre-reset out_valid", 32'(out_valid[0]), 32'(1));
        checkOutput("pre-reset out_data", 32'(out_data[0]), 32'(8'h40));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset out_valid", 32'(out_valid[0]), 32'(0));
        checkOutput("mid reset out_last", 32'(out_last[0]), 32'(0));
        checkOutput("mid reset out_data", 32'(out_data[0]), 32'(0));
        checkOutput("mid reset in_ready", 32'(in_ready[0]), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        blk = {};
        for (int i = 0; i < 16; i++) blk.push_back(8'(8'h90 + i));
        queueBlock(4, blk, 1'b0);
        applyStimulus(0, 4, 1'b0, 1'b0, 0, lat, bub, sa, rse);
        checkOutput("post-reset latency", 32'(lat), 32'(16));
        checkOutput("post-reset rx count", 32'(rxLanes.size()), 32'(16));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
